gen_event_dt_req: RTL
=====================

Name: gen_event_dt_req

Overview:
- Timestep requester for the emulation time manager. It holds a small in-order queue of absolute-time events.
- It drives a dt request so that emu_time lands exactly on the head event's timestamp.
- On arrival it pops the event and emits a one-cycle fire pulse carrying the event tag.
- One instance attaches to one dt_req_* input of the time manager. Its emu_time input comes from the time manager's emu_time output.

Parameters:
- TIME_WIDTH, 64, width of emu_time and of event timestamps.
- DT_WIDTH, 32, width of dt_req.
- DEPTH, 4, event queue entries; must be a power of 2 and at least 2.
- TAG_WIDTH, 8, width of the event tag.

Ports:
- emu_clk  input  1  emulation clock.
- emu_rst_n  input  1  asynchronous, active-low reset.
- emu_time  input  TIME_WIDTH  current emulation time from the time manager.
- ev_valid  input  1  event push request.
- ev_ready  output  1  queue can accept a push.
- ev_time  input  TIME_WIDTH  absolute timestamp of the pushed event.
- ev_tag  input  TAG_WIDTH  user tag of the pushed event.
- dt_req  output  DT_WIDTH  requested timestep toward the time manager.
- fire  output  1  one-cycle pulse: an event was popped.
- fire_tag  output  TAG_WIDTH  tag of the popped event.
- fire_time  output  TIME_WIDTH  emu_time at which the pop happened.
- level  output  log2(DEPTH)+1  number of queued events.
- late_err  output  1  sticky: an event was popped with emu_time > its timestamp.
- order_err  output  1  sticky: a push was dropped for an out-of-order timestamp.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - Queue empty; level = 0; fire = 0; fire_tag = 0; fire_time = 0; late_err = 0; order_err = 0.
  - last_time register = 0. ev_ready = 1.
- Queue:
  - Circular FIFO with read/write pointers of log2(DEPTH)+1 bits; full/empty come from the MSB compare.
  - ev_ready = !full. It is combinational from registered state only, with no bypass on same-cycle pop.
- Push (ev_valid && ev_ready at posedge):
  - If ev_time >= last_time, or the queue is empty and nothing has been pushed since reset: write {ev_time, ev_tag}, set last_time <= ev_time, and level increments.
  - Otherwise the event is dropped and order_err <= 1. The handshake still completes, so the producer does not stall.
  - Equal timestamps are allowed; they fire in push order, one per cycle.
- dt_req (combinational from emu_time and the registered head):
  - Empty: all-ones (DT_WIDTH'h…FF).
  - Head valid and head_time > emu_time: min(head_time - emu_time, all-ones). The subtraction is TIME_WIDTH wide; any set bit above DT_WIDTH-1 saturates.
  - Head valid and head_time <= emu_time: 0 (stall time until the pop).
- Pop (at posedge, when the head is valid and head_time <= emu_time):
  - The read pointer advances and level decrements.
  - Next cycle: fire = 1, fire_tag = head tag, fire_time = emu_time. Otherwise fire <= 0; fire_tag and fire_time hold.
  - If head_time < emu_time at the pop, late_err <= 1.
  - At most one pop per cycle. A backlog of due events pops on consecutive cycles, with dt_req = 0 throughout.
- Simultaneous push and pop:
  - Both take effect; level is unchanged.
  - A push into an empty queue is visible as the head on the following cycle, not the same cycle.
- Push with ev_time < emu_time: accepted if ordered, pops immediately, and sets late_err.
- Reset mid-operation: queue contents are discarded, all outputs go to their reset values, and dt_req returns to all-ones.
- No combinational path from ev_* to dt_req.
- The time manager adds dt_req to emu_time on every cycle. Exact arrival therefore holds for any head within 2^DT_WIDTH-1 of emu_time; larger gaps arrive in saturated steps.

Test Plan:
- Reset, empty queue, emu_time = 0 -> dt_req = 32'hFFFFFFFF, ev_ready = 1, level = 0, all flags 0.
- Push {t = 100, tag = 5} at emu_time = 0, time manager in loop -> dt_req = 100 the cycle after the push, emu_time reaches 100 exactly, dt_req = 0 for one cycle, then fire = 1 with fire_tag = 5, fire_time = 100, late_err = 0, dt_req back to all-ones.
- Push t = 10, 10, 20 (tags 1, 2, 3) -> fire tags 1, 2 on consecutive cycles at fire_time = 10, then tag 3 at 20; emu_time never exceeds 10 before both t = 10 pops.
- Fill DEPTH = 4 events, then push a fifth -> ev_ready = 0 while full. Pop one -> ev_ready = 1 the next cycle. Push t = 50 after last_time = 60 -> dropped, order_err = 1, level unchanged.
- Push t = 2^40 at emu_time = 0 -> dt_req = 32'hFFFFFFFF until the remaining gap < 2^32, then the exact remainder; fire at emu_time = 2^40.
- Hold emu_time externally at 200 with head t = 150 -> pop, late_err = 1. Assert emu_rst_n = 0 mid-queue -> level = 0, fire = 0, flags cleared immediately (async).

Source files
------------

// File: rtl/gen_event_dt_req.sv
// Timestep requester: queues absolute-time events in order and requests a dt
// from the time manager so emu_time lands exactly on the head event's timestamp.
module gen_event_dt_req #(
    parameter int TIME_WIDTH = 64,
    parameter int DT_WIDTH   = 32,
    parameter int DEPTH      = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                     emu_clk,
    input  logic                     emu_rst_n,
    input  logic [TIME_WIDTH-1:0]    emu_time,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic [TIME_WIDTH-1:0]    ev_time,
    input  logic [TAG_WIDTH-1:0]     ev_tag,
    output logic [DT_WIDTH-1:0]      dt_req,
    output logic                     fire,
    output logic [TAG_WIDTH-1:0]     fire_tag,
    output logic [TIME_WIDTH-1:0]    fire_time,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     late_err,
    output logic                     order_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [TIME_WIDTH-1:0] DT_MAX_T = {{(TIME_WIDTH-DT_WIDTH){1'b0}}, {DT_WIDTH{1'b1}}};

    logic [TIME_WIDTH-1:0] mem_time_r [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag_r  [DEPTH];
    logic [PTR_W:0]        wr_ptr_r;
    logic [PTR_W:0]        rd_ptr_r;
    logic [PTR_W:0]        level_r;
    logic [TIME_WIDTH-1:0] last_time_r;
    logic                  pushed_r;
    logic                  fire_r;
    logic [TAG_WIDTH-1:0]  fire_tag_r;
    logic [TIME_WIDTH-1:0] fire_time_r;
    logic                  late_err_r;
    logic                  order_err_r;

    logic                  empty_s;
    logic                  full_s;
    logic [TIME_WIDTH-1:0] head_time_s;
    logic [TAG_WIDTH-1:0]  head_tag_s;
    logic [TIME_WIDTH-1:0] gap_s;
    logic                  pop_s;
    logic                  push_hs_s;
    logic                  push_ok_s;
    logic [DT_WIDTH-1:0]   dt_req_s;

    assign empty_s     = (wr_ptr_r == rd_ptr_r);
    assign full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                         (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign head_time_s = mem_time_r[rd_ptr_r[PTR_W-1:0]];
    assign head_tag_s  = mem_tag_r[rd_ptr_r[PTR_W-1:0]];
    assign gap_s       = head_time_s - emu_time;
    assign pop_s       = !empty_s && (head_time_s <= emu_time);
    assign push_hs_s   = ev_valid && !full_s;
    // An out-of-order push still completes the handshake; it is only dropped.
    assign push_ok_s   = push_hs_s && ((ev_time >= last_time_r) || (empty_s && !pushed_r));

    // Timestep request: saturate large gaps, stall at zero while the head is due.
    always_comb begin
        dt_req_s = {DT_WIDTH{1'b1}};
        if (empty_s) begin
            dt_req_s = {DT_WIDTH{1'b1}};
        end else if (head_time_s > emu_time) begin
            if (gap_s > DT_MAX_T) begin
                dt_req_s = {DT_WIDTH{1'b1}};
            end else begin
                dt_req_s = gap_s[DT_WIDTH-1:0];
            end
        end else begin
            dt_req_s = {DT_WIDTH{1'b0}};
        end
    end

    // Queue storage, pointers, fire pulse and sticky error flags.
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_time_r[i] <= {TIME_WIDTH{1'b0}};
                mem_tag_r[i]  <= {TAG_WIDTH{1'b0}};
            end
            wr_ptr_r    <= {(PTR_W+1){1'b0}};
            rd_ptr_r    <= {(PTR_W+1){1'b0}};
            level_r     <= {(PTR_W+1){1'b0}};
            last_time_r <= {TIME_WIDTH{1'b0}};
            pushed_r    <= 1'b0;
            fire_r      <= 1'b0;
            fire_tag_r  <= {TAG_WIDTH{1'b0}};
            fire_time_r <= {TIME_WIDTH{1'b0}};
            late_err_r  <= 1'b0;
            order_err_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_time_r[wr_ptr_r[PTR_W-1:0]] <= ev_time;
                mem_tag_r[wr_ptr_r[PTR_W-1:0]]  <= ev_tag;
                wr_ptr_r    <= wr_ptr_r + PTR_ONE;
                last_time_r <= ev_time;
                pushed_r    <= 1'b1;
            end else if (push_hs_s) begin
                order_err_r <= 1'b1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_ONE;
                fire_r      <= 1'b1;
                fire_tag_r  <= head_tag_s;
                fire_time_r <= emu_time;
                if (head_time_s < emu_time) begin
                    late_err_r <= 1'b1;
                end else begin
                    late_err_r <= late_err_r;
                end
            end else begin
                fire_r <= 1'b0;
            end

            case ({push_ok_s, pop_s})
                2'b10:   level_r <= level_r + PTR_ONE;
                2'b01:   level_r <= level_r - PTR_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign ev_ready  = !full_s;
    assign dt_req    = dt_req_s;
    assign fire      = fire_r;
    assign fire_tag  = fire_tag_r;
    assign fire_time = fire_time_r;
    assign level     = level_r;
    assign late_err  = late_err_r;
    assign order_err = order_err_r;

endmodule
